// File: rtl/pll_cfg_seq.sv
// rtl/pll_cfg_seq.sv - PLL reconfiguration sequencer (NTSC/PAL fractional VCO retune)
//
// Drives the PLL reconfiguration core over a write-only Avalon-MM master.
// On a request it writes mode, M, K, C0 and start registers, then waits for
// the PLL to report a stable lock (or times out).
//
// Ports:
//   clk              management clock (50 MHz reference)
//   rst_n            asynchronous active-low reset
//   cfg_req          single-cycle reconfiguration request
//   cfg_pal          target mode with cfg_req: 1 = PAL, 0 = NTSC
//   pll_locked       PLL lock flag, asynchronous to clk
//   mgmt_waitrequest reconfiguration core stall
//   mgmt_write       Avalon write strobe
//   mgmt_address     register address
//   mgmt_writedata   register data
//   cfg_busy         sequence in progress
//   cfg_done         one-cycle pulse on successful re-lock
//   cfg_err          sticky lock-timeout flag
//   cfg_mode         last successfully applied mode
module pll_cfg_seq #(
    parameter logic [31:0] M_NTSC  = 32'h0001_0504,
    parameter logic [31:0] K_NTSC  = 32'd702807747,
    parameter logic [31:0] M_PAL   = 32'h0000_0404,
    parameter logic [31:0] K_PAL   = 32'd2537930535,
    parameter logic [31:0] C0_VAL  = 32'h0000_0404,
    parameter int          TIMEOUT = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic        cfg_pal,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        cfg_mode
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_LOCK, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         step, step_nxt;
    logic               tgt, tgt_nxt;
    logic               pend, pend_nxt;
    logic               pend_pal, pend_pal_nxt;
    logic [TIMEOUT-1:0] tcnt, tcnt_nxt, tcnt_inc;
    logic [3:0]         scnt, scnt_nxt;
    logic [1:0]         lock_sync;
    logic               write_nxt;
    logic [5:0]         addr_nxt;
    logic [31:0]        data_nxt;
    logic               busy_nxt, done_nxt, err_nxt, mode_nxt;

    // Register write table: {address, data} for each step.
    function automatic logic [37:0] tbl(input logic [2:0] s, input logic pal);
        case (s)
            3'd0:    tbl = {6'd0, 32'd0};
            3'd1:    tbl = {6'd4, (pal ? M_PAL : M_NTSC)};
            3'd2:    tbl = {6'd7, (pal ? K_PAL : K_NTSC)};
            3'd3:    tbl = {6'd5, C0_VAL};
            default: tbl = {6'd2, 32'd0};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            step           <= '0;
            tgt            <= 1'b0;
            pend           <= 1'b0;
            pend_pal       <= 1'b0;
            tcnt           <= '0;
            scnt           <= '0;
            lock_sync      <= '0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            cfg_mode       <= 1'b0;
        end else begin
            state          <= state_nxt;
            step           <= step_nxt;
            tgt            <= tgt_nxt;
            pend           <= pend_nxt;
            pend_pal       <= pend_pal_nxt;
            tcnt           <= tcnt_nxt;
            scnt           <= scnt_nxt;
            lock_sync      <= {lock_sync[0], pll_locked};
            mgmt_write     <= write_nxt;
            mgmt_address   <= addr_nxt;
            mgmt_writedata <= data_nxt;
            cfg_busy       <= busy_nxt;
            cfg_done       <= done_nxt;
            cfg_err        <= err_nxt;
            cfg_mode       <= mode_nxt;
        end
    end

    // Next-state logic; every output is computed here and registered above,
    // so nothing on the mgmt_* bus depends combinationally on an input.
    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        tgt_nxt      = tgt;
        pend_nxt     = pend;
        pend_pal_nxt = pend_pal;
        tcnt_nxt     = tcnt;
        scnt_nxt     = scnt;
        write_nxt    = mgmt_write;
        addr_nxt     = mgmt_address;
        data_nxt     = mgmt_writedata;
        busy_nxt     = cfg_busy;
        done_nxt     = 1'b0;
        err_nxt      = cfg_err;
        mode_nxt     = cfg_mode;
        tcnt_inc     = tcnt + TIMEOUT'(1);

        // Requests arriving mid-sequence collapse into one pending slot;
        // the most recent mode wins.
        if (cfg_req && state != S_IDLE) begin
            pend_nxt     = 1'b1;
            pend_pal_nxt = cfg_pal;
        end

        case (state)
            S_IDLE: begin
                if (cfg_req || pend) begin
                    tgt_nxt   = cfg_req ? cfg_pal : pend_pal;
                    pend_nxt  = 1'b0;
                    step_nxt  = 3'd0;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    write_nxt = 1'b1;
                    {addr_nxt, data_nxt} = tbl(3'd0, tgt_nxt);
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (!mgmt_waitrequest) begin
                    if (step == 3'd4) begin
                        write_nxt = 1'b0;
                        addr_nxt  = '0;
                        data_nxt  = '0;
                        tcnt_nxt  = '0;
                        scnt_nxt  = '0;
                        state_nxt = S_LOCK;
                    end else begin
                        step_nxt = step + 3'd1;
                        {addr_nxt, data_nxt} = tbl(step_nxt, tgt);
                    end
                end
            end
            S_LOCK: begin
                tcnt_nxt = tcnt_inc;
                if (lock_sync[1]) begin
                    scnt_nxt = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        mode_nxt  = tgt;
                        state_nxt = S_DONE;
                    end
                end else begin
                    // A glitch restarts stability but leaves the timeout running.
                    scnt_nxt = '0;
                end
                if (state_nxt != S_DONE && (&tcnt_inc)) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb/tb_pll_cfg_seq.sv - self-checking bench for pll_cfg_seq
module tb_pll_cfg_seq;

    localparam logic [31:0] M_NTSC = 32'h0001_0504;
    localparam logic [31:0] K_NTSC = 32'd702807747;
    localparam logic [31:0] M_PAL  = 32'h0000_0404;
    localparam logic [31:0] K_PAL  = 32'd2537930535;
    localparam logic [31:0] C0_VAL = 32'h0000_0404;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_pal = 1'b0;
    logic        pll_locked = 1'b0;
    logic        mgmt_waitrequest = 1'b0;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        cfg_busy, cfg_done, cfg_err, cfg_mode;

    int total = 0;
    int bad   = 0;

    pll_cfg_seq #(.TIMEOUT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_req          (cfg_req),
        .cfg_pal          (cfg_pal),
        .pll_locked       (pll_locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err),
        .cfg_mode         (cfg_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pal;
        int          stall;
        int          stall_start;
        int          lock_delay;
        logic [31:0] m;
        logic [31:0] k;
        logic        exp_mode;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_req(input logic pal);
        cfg_req = 1'b1;
        cfg_pal = pal;
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    // Full sequence with per-write stalls and a delayed lock; exact done latency.
    task automatic run_seq(input vec_t v);
        logic [5:0]  ea;
        logic [31:0] ed;
        int          s;
        pll_locked       = 1'b0;
        mgmt_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        do_req(v.pal);
        chk("busy_on", 64'(cfg_busy), 64'(1));
        chk("err_clr", 64'(cfg_err), 64'(0));
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin ea = 6'd0; ed = 32'd0;  end
                1:       begin ea = 6'd4; ed = v.m;    end
                2:       begin ea = 6'd7; ed = v.k;    end
                3:       begin ea = 6'd5; ed = C0_VAL; end
                default: begin ea = 6'd2; ed = 32'd0;  end
            endcase
            s = (i == 4) ? v.stall_start : v.stall;
            for (int k = 0; k <= s; k++) begin
                chk("wr_strobe", 64'(mgmt_write), 64'(1));
                chk("wr_addr", 64'(mgmt_address), 64'(ea));
                chk("wr_data", 64'(mgmt_writedata), 64'(ed));
                mgmt_waitrequest = (k < s);
                @(negedge clk);
            end
        end
        chk("wr_end", 64'(mgmt_write), 64'(0));
        chk("busy_lock", 64'(cfg_busy), 64'(1));
        repeat (v.lock_delay) @(negedge clk);
        pll_locked = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c < 18) begin
                chk("done_early", 64'(cfg_done), 64'(0));
                chk("busy_hold", 64'(cfg_busy), 64'(1));
            end
        end
        chk("done_pulse", 64'(cfg_done), 64'(1));
        chk("busy_off", 64'(cfg_busy), 64'(0));
        chk("mode", 64'(cfg_mode), 64'(v.exp_mode));
        @(negedge clk);
        chk("done_once", 64'(cfg_done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_cnt, err_early, wr_cnt, k_cnt, first_done_c, second_wr_c;
        logic [31:0] first_k, last_k;
        logic        first_mode, prev_write;
        vec_t        v;

        vecs[0] = '{1'b1, 0, 0, 40, M_PAL, K_PAL, 1'b1};
        vecs[1] = '{1'b0, 3, 200, 5, M_NTSC, K_NTSC, 1'b0};
        vecs[2] = '{1'b1, 1, 0, 0, M_PAL, K_PAL, 1'b1};
        vecs[3] = '{1'b0, 0, 0, 2, M_NTSC, K_NTSC, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_write", 64'(mgmt_write), 64'(0));
        chk("rst_addr", 64'(mgmt_address), 64'(0));
        chk("rst_data", 64'(mgmt_writedata), 64'(0));
        chk("rst_busy", 64'(cfg_busy), 64'(0));
        chk("rst_done", 64'(cfg_done), 64'(0));
        chk("rst_err", 64'(cfg_err), 64'(0));
        chk("rst_mode", 64'(cfg_mode), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_seq(vecs[i]);

        // Lock timeout: 255 LOCK cycles, mode unchanged
        pll_locked = 1'b0;
        mgmt_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b1);
        repeat (5) @(negedge clk);
        done_cnt = 0;
        err_early = 0;
        for (int c = 0; c < 254; c++) begin
            if (cfg_done) done_cnt++;
            if (cfg_err) err_early++;
            @(negedge clk);
        end
        chk("to_err_early", 64'(err_early), 64'(0));
        chk("to_busy_before", 64'(cfg_busy), 64'(1));
        @(negedge clk);
        chk("to_err", 64'(cfg_err), 64'(1));
        chk("to_busy", 64'(cfg_busy), 64'(0));
        chk("to_mode", 64'(cfg_mode), 64'(0));
        chk("to_no_done", 64'(done_cnt + int'(cfg_done)), 64'(0));
        v = '{1'b1, 0, 0, 1, M_PAL, K_PAL, 1'b1};
        run_seq(v);

        // Pending requests: PAL then NTSC while busy, last one wins
        pll_locked = 1'b1;
        mgmt_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        done_cnt = 0; wr_cnt = 0; k_cnt = 0;
        first_k = 0; last_k = 0; first_mode = 1'b0;
        first_done_c = -1; second_wr_c = -1; prev_write = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (mgmt_write) wr_cnt++;
            if (mgmt_write && !prev_write && first_done_c >= 0 && second_wr_c < 0)
                second_wr_c = c;
            if (mgmt_write && mgmt_address == 6'd7) begin
                k_cnt++;
                if (k_cnt == 1) first_k = mgmt_writedata;
                last_k = mgmt_writedata;
            end
            if (cfg_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_mode = cfg_mode;
                    first_done_c = c;
                end
            end
            prev_write = mgmt_write;
            cfg_req = (c == 0) || (c == 3) || (c == 5);
            cfg_pal = (c == 0) || (c == 3);
            @(negedge clk);
        end
        cfg_req = 1'b0;
        chk("pend_done_cnt", 64'(done_cnt), 64'(2));
        chk("pend_wr_cnt", 64'(wr_cnt), 64'(10));
        chk("pend_k_cnt", 64'(k_cnt), 64'(2));
        chk("pend_first_k", 64'(first_k), 64'(K_PAL));
        chk("pend_last_k", 64'(last_k), 64'(K_NTSC));
        chk("pend_first_mode", 64'(first_mode), 64'(1));
        chk("pend_gap", 64'(second_wr_c - first_done_c), 64'(2));
        chk("pend_final_mode", 64'(cfg_mode), 64'(0));
        chk("pend_idle", 64'(cfg_busy), 64'(0));

        // Lock glitch at LOCK+10 restarts the stability count
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b1);
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        repeat (10) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c < 18 && cfg_done) done_cnt++;
        end
        chk("glitch_early", 64'(done_cnt), 64'(0));
        chk("glitch_done", 64'(cfg_done), 64'(1));
        chk("glitch_mode", 64'(cfg_mode), 64'(1));

        // Reset during a stalled step-2 write
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b1);
        @(negedge clk);
        @(negedge clk);
        mgmt_waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_write", 64'(mgmt_write), 64'(1));
        chk("stall_addr", 64'(mgmt_address), 64'(7));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_write", 64'(mgmt_write), 64'(0));
        chk("arst_addr", 64'(mgmt_address), 64'(0));
        chk("arst_data", 64'(mgmt_writedata), 64'(0));
        chk("arst_busy", 64'(cfg_busy), 64'(0));
        chk("arst_err", 64'(cfg_err), 64'(0));
        chk("arst_mode", 64'(cfg_mode), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        mgmt_waitrequest = 1'b0;
        v = '{1'b1, 0, 0, 3, M_PAL, K_PAL, 1'b1};
        run_seq(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_cfg_seq.md
# pll_cfg_seq

Reconfiguration sequencer for the system PLL: the management-side master that drives the PLL reconfiguration core, which in turn drives the PLL's `reconfig_to_pll` bus and reads `reconfig_from_pll`. On request, it retunes the fractional VCO between the NTSC (57.272719 MHz CLK0) and PAL (53.693175 MHz CLK0) video-timing plans. It writes the M, K and C0 registers over an Avalon-MM write-only master, triggers the update, and reports completion once the PLL re-locks. It sits in the top level on the 50 MHz reference clock.

## Interface
Parameters:
- `M_NTSC`, 32'h0001_0504: M counter word for NTSC (hi 5, lo 4, odd-duty).
- `K_NTSC`, 32'd702807747: fractional K for NTSC.
- `M_PAL`, 32'h0000_0404: M counter word for PAL (hi 4, lo 4).
- `K_PAL`, 32'd2537930535: fractional K for PAL.
- `C0_VAL`, 32'h0000_0404: C0 word (index 0, hi 4, lo 4); shared by both modes.
- `TIMEOUT`, 20: width of the lock-wait counter; timeout occurs at 2^TIMEOUT−1 cycles.

Ports:
- `clk`  in  1  management clock (50 MHz reference).
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `cfg_req`  in  1  single-cycle request to reconfigure.
- `cfg_pal`  in  1  target mode sampled with `cfg_req`: 1 = PAL, 0 = NTSC.
- `pll_locked`  in  1  PLL locked flag. Asynchronous to `clk`; synchronized internally with 2 FFs.
- `mgmt_waitrequest`  in  1  reconfiguration core stall.
- `mgmt_write`  out  1  Avalon write strobe.
- `mgmt_address`  out  6  register address.
- `mgmt_writedata`  out  32  register data.
- `cfg_busy`  out  1  high from request acceptance until done or error.
- `cfg_done`  out  1  one-cycle pulse on successful re-lock.
- `cfg_err`  out  1  sticky lock-timeout flag; cleared on the next accepted request.
- `cfg_mode`  out  1  last successfully applied mode.

## Operation
- Write table, indexed by `step` 0..4:
  - step 0: addr 0, data 0 (mode register, waitrequest mode).
  - step 1: addr 4, M word.
  - step 2: addr 7, K.
  - step 3: addr 5, `C0_VAL`.
  - step 4: addr 2, data 0 (start).
  - M and K are selected by the latched mode bit `tgt`.
- States:
  - IDLE: on `cfg_req` (or a pending request), latch `tgt`, set `step`=0, clear `cfg_err`, go to WR.
  - WR: assert `mgmt_write` with the table entry for `step`. Address, data and strobe stay stable while `mgmt_waitrequest`=1. On an edge where `mgmt_waitrequest`=0, the transfer completes:
    - if `step`<4: `step`++ and stay in WR (back-to-back writes allowed);
    - if `step`=4: go to LOCK.
  - LOCK: clear the timeout counter on entry, then count each cycle.
    - Synced locked = 1 for 16 consecutive cycles: go to DONE.
    - Counter reaches all-ones first: set `cfg_err` and return to IDLE. `cfg_mode` is unchanged.
  - DONE: set `cfg_mode`=`tgt`, pulse `cfg_done` for 1 cycle, go to IDLE.
- `cfg_req` while busy: set the pending flag and store the latest `cfg_pal` (last request wins). The pending request is serviced from IDLE on the cycle after DONE or after an error.
- A request for a mode equal to `cfg_mode` is still executed in full; there is no skipping.
- Writes only: `mgmt_read` is not implemented. The reconfiguration core's read port is tied off at top level.

## Timing
- Reset values:
  - `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0;
  - `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0;
  - `cfg_mode`=0 (NTSC, matching the PLL power-up configuration);
  - pending flag cleared, state IDLE.
- `cfg_req` at edge N: `cfg_busy`=1 and `mgmt_write`=1 (step 0) from edge N+1.
- With `mgmt_waitrequest` permanently 0, the five writes occupy cycles N+1..N+5 and LOCK is entered at N+6.
- Minimum request-to-`cfg_done`: 5 write cycles + 2 sync + 16 stable cycles + 1.
- `cfg_busy` falls in the same cycle that `cfg_done` pulses, or the cycle `cfg_err` rises.
- A locked glitch (0 for any cycle) during the 16-cycle window restarts the stability count. It does not reset the timeout counter.
- `rst_n` low mid-sequence: all outputs return to reset values asynchronously, and `mgmt_write` drops immediately. The reconfiguration core shares `rst_n`, so no half-transfer survives.
- Outputs are registered. No combinational path from inputs to `mgmt_*`.

## Test plan
- NTSC → PAL, waitrequest=0, locked returns after 40 cycles:
  - writes (0,0), (4,32'h0000_0404), (7,2537930535), (5,32'h0000_0404), (2,0) on five consecutive cycles;
  - `cfg_done` pulses once; `cfg_mode`=1; `cfg_busy` high exactly from the request until done.
- Waitrequest stalls 3 cycles on each write and 200 cycles on the start write:
  - address and data hold stable through every stall;
  - no write is duplicated or skipped;
  - the sequence completes with `cfg_mode` matching the request.
- `pll_locked` held 0 with TIMEOUT=8:
  - `cfg_err`=1 after 255 LOCK cycles;
  - no `cfg_done`; `cfg_mode` unchanged; `cfg_busy`=0;
  - the next `cfg_req` clears `cfg_err`.
- Requests PAL then NTSC issued during a busy sequence:
  - exactly one follow-up sequence runs, using NTSC K=702807747;
  - final `cfg_mode`=0; two `cfg_done` pulses in total.
- Locked toggles 0 for one cycle at LOCK+10: the stability count restarts and `cfg_done` arrives 16 stable cycles after the glitch.
- `rst_n` asserted during step 2 with waitrequest high: `mgmt_write`=0 asynchronously, all flags cleared, `cfg_mode`=0; a new request after release runs from step 0.
